// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - state_e    : controller FSM states
//   - FWD_*      : forwarding-mux select encodings used by the datapath
//   - NOP_INSTR  : instruction word a flushed pipeline register represents
//   - load_use_hazard() : load-use detection between EX and ID
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_START = 2'd1,
        MD_WAIT  = 2'd2
    } state_e;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_IFID  = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // x0 never carries a real dependency, and a source the ID instruction does
    // not read cannot create one.
    function automatic logic load_use_hazard(
        input logic       ex_memread,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_use_rs1,
        input logic       id_use_rs2
    );
        return ex_memread && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones.
//   clk    : clock
//   rst_n  : asynchronous active-low clear
//   i_clr  : synchronous clear (wins over i_inc)
//   i_inc  : increment enable
//   o_cnt  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Stall / flush / bubble control for the 5-stage RV32 pipeline, plus the
// start/done sequencer for the multi-cycle MUL/DIV unit in EX.
//   clk, rst_n                     : clock, async active-low reset
//   idex_memread, idex_rd          : EX instruction is a load, and its rd
//   ifid_rs1/rs2, ifid_use_rs1/rs2 : ID sources and whether they are read
//   ex_branch_taken                : redirect resolved in EX
//   ex_md_valid, md_done           : MUL/DIV in EX, result-ready pulse
//   pc_write, ifid_write, idex_write : register enables
//   ifid_flush, idex_flush         : turn the register into a NOP
//   exmem_bubble                   : load a NOP into EX/MEM
//   md_start                       : one-cycle start pulse to MUL/DIV
//   md_error                       : sticky MUL/DIV timeout flag
//   stall_cnt                      : saturating count of pc_write=0 cycles
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             ex_branch_taken,
    input  logic             ex_md_valid,
    input  logic             md_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             md_start,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int            TO_W    = $clog2(MD_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    state_e          r_state;
    logic            r_md_error;
    logic [TO_W-1:0] w_to_cnt;
    logic            w_load_use;
    logic            w_to_hit;

    assign w_load_use = load_use_hazard(idex_memread, idex_rd, ifid_rs1, ifid_rs2,
                                        ifid_use_rs1, ifid_use_rs2);
    assign w_to_hit   = (w_to_cnt == TO_LAST);

    // Outputs are combinational so the pipeline registers react at the very
    // next edge. Reset forces the free-running defaults even if inputs toggle.
    // NOTE: every output gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                RUN: begin
                    if (ex_branch_taken) begin
                        // The ID instruction is squashed, so its hazard is moot.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (ex_md_valid) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                    end else if (w_load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                MD_START: begin
                    // A same-cycle done releases at once (zero wait cycles).
                    if (!md_done) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        // Release with the result advancing into EX/MEM.
                    end else if (w_to_hit) begin
                        // Release, but drop the missing result.
                        exmem_bubble = 1'b1;
                    end else begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_md_error <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (!ex_branch_taken && ex_md_valid) begin
                        r_state <= MD_START;
                    end
                end
                MD_START: begin
                    r_state <= md_done ? RUN : MD_WAIT;
                end
                MD_WAIT: begin
                    if (md_done) begin
                        r_state <= RUN;
                    end else if (w_to_hit) begin
                        r_state    <= RUN;
                        r_md_error <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign md_start = (r_state == MD_START);
    assign md_error = r_md_error;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (1'b0),
        .i_inc (~pc_write),
        .o_cnt (stall_cnt)
    );

    // Cleared while issuing the start pulse, so it counts MD_WAIT cycles from 0.
    sat_counter #(.W(TO_W)) u_md_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (r_state == MD_START),
        .i_inc (r_state == MD_WAIT),
        .o_cnt (w_to_cnt)
    );

endmodule
